// File: rtl/column_hit_reader.sv
// column_hit_reader: reader end of the pixel L1-event-buffer read interface.
// Scans one column's unreadHit flags round-robin. For the selected pixel it pulses
// load, captures the shared column bus, then pulses read. The captured word, tagged
// with the pixel index, is offered downstream on a valid/ready port.
module column_hit_reader #(
   parameter int unsigned NPIX = 16,
   parameter int unsigned PIDW = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 clrCount,
   input  logic [NPIX-1:0]      unreadHit,
   input  logic [35:0]          colDout,
   output logic [NPIX-1:0]      load,
   output logic [NPIX-1:0]      read,
   output logic [PIDW+35:0]     outData,
   output logic                 outValid,
   input  logic                 outReady,
   output logic                 busy,
   output logic [15:0]          wordCount
);

   localparam int unsigned DW = 36;
   localparam int unsigned OW = PIDW + DW;
   localparam int unsigned CW = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CAPT,
      S_READ,
      S_OUT
   } state_e;

   state_e            state_q, state_d;
   logic [PIDW-1:0]   sel_q, sel_d;
   logic [PIDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NPIX-1:0]   load_q, load_d;
   logic [NPIX-1:0]   read_q, read_d;
   logic [OW-1:0]     out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic [CW-1:0]     word_count_q, word_count_d;

   logic              win_found_c;
   logic [PIDW-1:0]   win_idx_c;
   logic [PIDW-1:0]   cand_c;
   logic              accept_c;

   // Pixel index + 1 with wrap at NPIX-1 (NPIX need not be a power of two).
   function automatic logic [PIDW-1:0] wrap_inc(input logic [PIDW-1:0] p);
      if (p == PIDW'(NPIX - 1)) begin
         return '0;
      end
      return p + PIDW'(1);
   endfunction

   // Round-robin arbiter: first set unreadHit bit at or above rr_ptr, wrapping to 0.
   always_comb begin
      win_found_c = 1'b0;
      win_idx_c   = '0;
      cand_c      = rr_ptr_q;
      for (int unsigned k = 0; k < NPIX; k++) begin
         if (!win_found_c && unreadHit[cand_c]) begin
            win_found_c = 1'b1;
            win_idx_c   = cand_c;
         end
         cand_c = wrap_inc(cand_c);
      end
   end

   assign accept_c = out_valid_q & outReady;

   // Next-state and registered-output logic for the load/capture/read/offer sequence.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      rr_ptr_d    = rr_ptr_q;
      load_d      = '0;
      read_d      = '0;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         S_IDLE: begin
            if (enable && win_found_c) begin
               state_d = S_LOAD;
               sel_d   = win_idx_c;
               load_d  = NPIX'(1) << win_idx_c;
            end
         end
         S_LOAD: begin
            state_d = S_CAPT;
         end
         S_CAPT: begin
            out_data_d = {sel_q, colDout};
            read_d     = NPIX'(1) << sel_q;
            state_d    = S_READ;
         end
         S_READ: begin
            rr_ptr_d    = wrap_inc(sel_q);
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (accept_c) begin
               out_valid_d = 1'b0;
               if (enable && win_found_c) begin
                  state_d = S_LOAD;
                  sel_d   = win_idx_c;
                  load_d  = NPIX'(1) << win_idx_c;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // Accepted-word counter: clear wins over increment, saturates at all ones.
   always_comb begin
      word_count_d = word_count_q;
      if (clrCount) begin
         word_count_d = '0;
      end else if (accept_c && (word_count_q != {CW{1'b1}})) begin
         word_count_d = word_count_q + CW'(1);
      end
   end

   // State and output registers; reset abandons any sequence in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         sel_q        <= '0;
         rr_ptr_q     <= '0;
         load_q       <= '0;
         read_q       <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         rr_ptr_q     <= rr_ptr_d;
         load_q       <= load_d;
         read_q       <= read_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         busy_q       <= busy_d;
         word_count_q <= word_count_d;
      end
   end

   assign load      = load_q;
   assign read      = read_q;
   assign outData   = out_data_q;
   assign outValid  = out_valid_q;
   assign busy      = busy_q;
   assign wordCount = word_count_q;

endmodule

// File: tb/tb_column_hit_reader.sv
// Testbench for column_hit_reader: latency table, hand-written corner sequences,
// and a randomized run against a transaction-level model with emulated pixels.
module tb_column_hit_reader;

   localparam int unsigned NPIX = 16;
   localparam int unsigned PIDW = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic              clrCount;
   logic [NPIX-1:0]   unreadHit;
   logic [35:0]       colDout;
   logic [NPIX-1:0]   load;
   logic [NPIX-1:0]   read;
   logic [PIDW+35:0]  outData;
   logic              outValid;
   logic              outReady;
   logic              busy;
   logic [15:0]       wordCount;

   int n_chk  = 0;
   int n_fail = 0;

   column_hit_reader #(.NPIX(NPIX), .PIDW(PIDW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .clrCount(clrCount),
      .unreadHit(unreadHit), .colDout(colDout), .load(load), .read(read),
      .outData(outData), .outValid(outValid), .outReady(outReady),
      .busy(busy), .wordCount(wordCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; enable = 1'b0; clrCount = 1'b0; unreadHit = '0;
      colDout = '0; outReady = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic wait_valid(input string nm);
      int t;
      t = 0;
      while (!outValid && t < 30) begin
         step();
         t++;
      end
      if (!outValid) chk({nm, "_timeout"}, 64'(outValid), 64'd1);
   endtask

   function automatic logic [NPIX-1:0] onehot(input int p);
      return NPIX'(1) << p;
   endfunction

   function automatic int first_from(input logic [NPIX-1:0] h, input int rr);
      for (int k = 0; k < int'(NPIX); k++) begin
         if (h[(rr + k) % int'(NPIX)]) return (rr + k) % int'(NPIX);
      end
      return -1;
   endfunction

   function automatic logic [35:0] pix_word(input int p, input int s);
      return {4'(p), 16'(s), 16'(s * 37 + p * 101)};
   endfunction

   typedef struct {
      logic        en;
      logic [15:0] hit;
      logic        rdy;
      logic [15:0] e_load;
      logic [15:0] e_read;
      logic        e_valid;
      logic        e_busy;
      logic        chk_data;
      logic [39:0] e_data;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[6];

   // model / environment state for the randomized run
   int            cnt[NPIX];
   int            head[NPIX];
   logic [39:0]   exp_q[$];
   logic [39:0]   e_word;
   int            m_rr, last_ld, n_acc, order[$], idx;
   logic          m_free, acc, p_en, p_rdy, p_clr, prev_valid;
   logic [15:0]   p_hit, m_cnt, h;
   logic [39:0]   prev_data, snap;

   initial begin
      do_reset();

      // single hit latency trace, pixel 5
      tbl[0] = '{1'b1, 16'h0020, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b1, 1'b0, 40'h0, 16'd0};
      tbl[1] = '{1'b1, 16'h0020, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 40'h0, 16'd0};
      tbl[2] = '{1'b1, 16'h0020, 1'b1, 16'h0000, 16'h0020, 1'b0, 1'b1, 1'b1, 40'h5ABCDEF012, 16'd0};
      tbl[3] = '{1'b1, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 40'h5ABCDEF012, 16'd0};
      tbl[4] = '{1'b1, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 40'h0, 16'd1};
      tbl[5] = '{1'b1, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 40'h0, 16'd1};
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(outValid), 64'd0);
      chk("rst_data", 64'(outData), 64'd0);
      colDout = 36'hABCDEF012;
      for (int i = 0; i < 6; i++) begin
         enable = tbl[i].en; unreadHit = tbl[i].hit; outReady = tbl[i].rdy;
         step();
         chk($sformatf("tbl%0d_load", i), 64'(load), 64'(tbl[i].e_load));
         chk($sformatf("tbl%0d_read", i), 64'(read), 64'(tbl[i].e_read));
         chk($sformatf("tbl%0d_valid", i), 64'(outValid), 64'(tbl[i].e_valid));
         chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
         chk($sformatf("tbl%0d_cnt", i), 64'(wordCount), 64'(tbl[i].e_cnt));
         if (tbl[i].chk_data) chk($sformatf("tbl%0d_data", i), 64'(outData), 64'(tbl[i].e_data));
      end

      // reset while in LOAD, then the loaded pixel is served again
      unreadHit = 16'h0040;
      step();
      chk("mid_load", 64'(load), 64'h0040);
      #2 reset = 1'b0;
      #1;
      chk("arst_load", 64'(load), 64'd0);
      chk("arst_read", 64'(read), 64'd0);
      chk("arst_valid", 64'(outValid), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_cnt", 64'(wordCount), 64'd0);
      step();
      reset = 1'b1;
      step();
      chk("reserve_load", 64'(load), 64'h0040);
      unreadHit = '0;
      repeat (6) step();

      // round robin between pixels 0 and 15
      do_reset();
      enable = 1'b1; outReady = 1'b1; unreadHit = 16'h8001;
      for (int t = 0; t < 40 && order.size() < 4; t++) begin
         step();
         for (int i = 0; i < int'(NPIX); i++) if (load[i]) order.push_back(i);
      end
      chk("rr_count", 64'(order.size()), 64'd4);
      for (int i = 0; i < 4 && i < order.size(); i++)
         chk($sformatf("rr_order%0d", i), 64'(order[i]), (i % 2 == 0) ? 64'd0 : 64'd15);

      // backpressure: stall in OUT for 10 cycles
      do_reset();
      enable = 1'b1; unreadHit = 16'h0004; colDout = 36'h123456789;
      wait_valid("bp");
      snap = outData;
      chk("bp_data", 64'(snap), 64'h2123456789);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_hold_valid", 64'(outValid), 64'd1);
         chk("bp_hold_data", 64'(outData), 64'(snap));
         chk("bp_no_load", 64'(load | read), 64'd0);
      end
      outReady = 1'b1;
      step();
      chk("bp_acc_valid", 64'(outValid), 64'd0);
      chk("bp_next_load", 64'(load), 64'h0004);
      chk("bp_cnt", 64'(wordCount), 64'd1);

      // enable dropped while in CAPT
      do_reset();
      enable = 1'b1; outReady = 1'b1; unreadHit = 16'h0002;
      step();
      chk("en_load", 64'(load), 64'h0002);
      step();
      enable = 1'b0;
      wait_valid("en");
      chk("en_data", 64'(outData[39:36]), 64'd1);
      step();
      chk("en_acc_valid", 64'(outValid), 64'd0);
      chk("en_cnt", 64'(wordCount), 64'd1);
      for (int i = 0; i < 3; i++) begin
         chk("en_idle_busy", 64'(busy), 64'd0);
         chk("en_idle_load", 64'(load), 64'd0);
         step();
      end

      // counter saturation and clear priority
      do_reset();
      force dut.word_count_q = 16'hFFFE;
      #1;
      release dut.word_count_q;
      chk("cnt_preload", 64'(wordCount), 64'hFFFE);
      enable = 1'b1; outReady = 1'b1; unreadHit = 16'h0001;
      for (int w = 0; w < 3; w++) begin
         wait_valid("cnt");
         step();
         chk($sformatf("cnt_sat%0d", w), 64'(wordCount), 64'hFFFF);
      end
      wait_valid("cnt_clr");
      clrCount = 1'b1;
      step();
      clrCount = 1'b0;
      chk("cnt_clr_acc", 64'(wordCount), 64'd0);

      // randomized run against the transaction-level model
      do_reset();
      for (int p = 0; p < int'(NPIX); p++) begin cnt[p] = 0; head[p] = 0; end
      m_rr = 0; m_free = 1'b1; m_cnt = '0; last_ld = 0; n_acc = 0;
      prev_valid = 1'b0; prev_data = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         enable   = ($urandom_range(0, 9) != 0);
         outReady = ($urandom_range(0, 9) < 7);
         clrCount = ($urandom_range(0, 79) == 0);
         for (int p = 0; p < int'(NPIX); p++) if ($urandom_range(0, 47) == 0) cnt[p]++;
         for (int p = 0; p < int'(NPIX); p++) h[p] = (cnt[p] > 0);
         unreadHit = h;
         colDout = pix_word(last_ld, head[last_ld]);
         p_en = enable; p_rdy = outReady; p_clr = clrCount; p_hit = unreadHit;
         step();

         acc = prev_valid && p_rdy;
         if (acc) begin
            n_acc++;
            if (exp_q.size() == 0) chk("rnd_unexpected_word", 64'(prev_data), 64'hDEAD);
            else begin
               e_word = exp_q.pop_front();
               chk("rnd_data", 64'(prev_data), 64'(e_word));
            end
         end
         if ((m_free || acc) && p_en && (p_hit != 0)) begin
            idx = first_from(p_hit, m_rr);
            chk("rnd_load", 64'(load), 64'(onehot(idx)));
            exp_q.push_back({4'(idx), pix_word(idx, head[idx])});
            last_ld = idx;
            m_rr = (idx + 1) % int'(NPIX);
            m_free = 1'b0;
         end else begin
            chk("rnd_no_load", 64'(load), 64'd0);
            if (m_free || acc) m_free = 1'b1;
         end
         if (p_clr) m_cnt = '0;
         else if (acc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         chk("rnd_cnt", 64'(wordCount), 64'(m_cnt));
         chk("rnd_busy", 64'(busy), 64'(!m_free));
         if (read != 0) begin
            chk("rnd_read", 64'(read), 64'(onehot(last_ld)));
            if (cnt[last_ld] > 0) begin cnt[last_ld]--; head[last_ld]++; end
         end
         if (prev_valid && !p_rdy) begin
            chk("rnd_stall_valid", 64'(outValid), 64'd1);
            chk("rnd_stall_data", 64'(outData), 64'(prev_data));
         end
         prev_valid = outValid;
         prev_data  = outData;
      end
      chk("rnd_accepts", 64'(n_acc >= 100), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
